vmicro16_apb_rr_arbiter: RTL and testbench

//   Round-robin arbiter placing MASTER_PORTS core APB master ports onto one shared APB bus.

---
 rtl/vmicro16_apb_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_vmicro16_apb_rr_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmicro16_apb_rr_arbiter.sv
// Round-robin arbiter placing several APB master ports onto one shared APB bus.
// The winning request is latched in IDLE, the arbiter then drives SETUP and ACCESS
// on the shared bus and routes PRDATA/PREADY back to the owner. A watchdog forces
// completion (with ERR_DATA and a timeout pulse) when the slave never answers.
//
// Handshake: a master requests by holding S_PSELx[i]. Its transfer is complete in
// the cycle S_PREADY[i]=1, and S_PRDATA[i] is valid only in that cycle. On the shared
// side the slave completes an ACCESS cycle by asserting M_PREADY. Request inputs are
// sampled only in IDLE. The master that just finished is masked for one IDLE cycle,
// so a PSELx still high after its PREADY is not regranted.
module vmicro16_apb_rr_arbiter #(
  parameter int                    MASTER_PORTS = 4,
  parameter int                    BUS_WIDTH    = 20,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    TIMEOUT      = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA     = 16'hDEAD
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic                               M_PSEL,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [DATA_WIDTH-1:0]              M_PRDATA,
  input  logic                               M_PREADY,
  output logic [MASTER_PORTS-1:0]            grant,
  output logic                               timeout,
  output logic [1:0]                         dbg_state
);

  localparam int PW = $clog2(MASTER_PORTS);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           owner;
  logic [PW-1:0]           winner;
  logic [MASTER_PORTS-1:0] mask;
  logic [MASTER_PORTS-1:0] req;
  logic [WW-1:0]           wdog;
  logic                    found;
  logic                    forced;
  logic                    done;

  // Phases are generated internally, so the masters' own enables carry no information.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  assign dbg_state = state;

  // Pick the first unmasked requester, scanning upward from ptr with wrap-around.
  always_comb begin
    req    = S_PSELx & ~mask;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < MASTER_PORTS; k++) begin
      if (!found && req[(int'(ptr) + k) % MASTER_PORTS]) begin
        found  = 1'b1;
        winner = PW'((int'(ptr) + k) % MASTER_PORTS);
      end
    end
  end

  // Completion detection; a slave ready in the last watchdog cycle beats the forced end.
  always_comb begin
    forced = (state == ST_ACCESS) && !M_PREADY && (wdog == WW'(TIMEOUT - 1));
    done   = (state == ST_ACCESS) && (M_PREADY || forced);
  end

  // Next-state logic for the IDLE -> SETUP -> ACCESS -> IDLE sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (found) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Shared-bus phase outputs and the return path to the current owner only.
  always_comb begin
    M_PSEL    = (state != ST_IDLE);
    M_PENABLE = (state == ST_ACCESS);
    S_PREADY  = '0;
    S_PRDATA  = '0;
    timeout   = forced;
    if (state == ST_ACCESS) begin
      S_PREADY[owner] = M_PREADY || forced;
      S_PRDATA[int'(owner)*DATA_WIDTH +: DATA_WIDTH] = forced ? ERR_DATA : M_PRDATA;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Arbitration bookkeeping, watchdog and latched shared-bus request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      owner    <= '0;
      grant    <= '0;
      mask     <= '0;
      wdog     <= '0;
      M_PADDR  <= '0;
      M_PWRITE <= 1'b0;
      M_PWDATA <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mask <= '0;
          if (found) begin
            owner    <= winner;
            grant    <= MASTER_PORTS'(1) << winner;
            M_PADDR  <= S_PADDR[int'(winner)*BUS_WIDTH +: BUS_WIDTH];
            M_PWRITE <= S_PWRITE[winner];
            M_PWDATA <= S_PWDATA[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ST_ACCESS: begin
          if (done) begin
            ptr   <= (owner == PW'(MASTER_PORTS - 1)) ? '0 : owner + PW'(1);
            mask  <= grant;
            grant <= '0;
            wdog  <= '0;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_apb_rr_arbiter.sv
// Bench for vmicro16_apb_rr_arbiter: directed transfers against a programmable-wait
// slave model, with a queue-based scoreboard checked whenever any S_PREADY fires.
module tb_vmicro16_apb_rr_arbiter;

  localparam int N  = 4;
  localparam int BW = 20;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int EW = 4 + N*DW + 1 + BW + 1 + DW;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N*BW-1:0] S_PADDR   = '0;
  logic [N-1:0]    S_PWRITE  = '0;
  logic [N-1:0]    S_PSELx   = '0;
  logic [N-1:0]    S_PENABLE = '0;
  logic [N*DW-1:0] S_PWDATA  = '0;
  logic [N*DW-1:0] S_PRDATA;
  logic [N-1:0]    S_PREADY;
  logic [BW-1:0]   M_PADDR;
  logic            M_PWRITE;
  logic            M_PSEL;
  logic            M_PENABLE;
  logic [DW-1:0]   M_PWDATA;
  logic [DW-1:0]   M_PRDATA;
  logic            M_PREADY;
  logic [N-1:0]    grant;
  logic            timeout;
  logic [1:0]      dbg_state;

  vmicro16_apb_rr_arbiter #(
    .MASTER_PORTS(N), .BUS_WIDTH(BW), .DATA_WIDTH(DW), .TIMEOUT(TO), .ERR_DATA(16'hDEAD)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .grant(grant), .timeout(timeout), .dbg_state(dbg_state)
  );

  // Slave model: ready after slave_wait idle ACCESS cycles; negative means never.
  int            slave_wait  = 0;
  logic [DW-1:0] slave_rdata = '0;
  logic [7:0]    acc_cnt     = '0;
  always @(posedge clk) begin
    if (M_PENABLE && !M_PREADY) acc_cnt <= acc_cnt + 8'd1;
    else                        acc_cnt <= '0;
  end
  assign M_PREADY = M_PENABLE && (slave_wait >= 0) && (int'(acc_cnt) == slave_wait);
  assign M_PRDATA = slave_rdata;

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_item;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [BW-1:0] a, input logic w,
                            input logic [DW-1:0] d);
    S_PADDR[i*BW +: BW]  = a;
    S_PWRITE[i]          = w;
    S_PWDATA[i*DW +: DW] = d;
    S_PSELx[i]           = 1'b1;
  endtask

  task automatic push_exp(input int i, input logic [DW-1:0] rd, input logic to,
                          input logic [BW-1:0] a, input logic w, input logic [DW-1:0] d);
    logic [N-1:0]    g;
    logic [N*DW-1:0] prd;
    g   = '0;
    g[i] = 1'b1;
    prd = '0;
    prd[i*DW +: DW] = rd;
    exp_q.push_back({g, prd, to, a, w, d});
  endtask

  // Monitor: every completion pops one expected transfer and compares it.
  always @(negedge clk) begin
    if (!reset && S_PREADY != '0) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_pready", {60'd0, S_PREADY}, 64'd0);
      end else begin
        mon_item = exp_q.pop_front();
        chk("mon_grant",   {60'd0, S_PREADY}, {60'd0, mon_item[EW-1 -: 4]});
        chk("mon_prdata",  S_PRDATA, mon_item[EW-5 -: N*DW]);
        chk("mon_timeout", {63'd0, timeout}, {63'd0, mon_item[BW+DW+1]});
        chk("mon_paddr",   {44'd0, M_PADDR}, {44'd0, mon_item[BW+DW : DW+1]});
        chk("mon_pwrite",  {63'd0, M_PWRITE}, {63'd0, mon_item[DW]});
        chk("mon_pwdata",  {48'd0, M_PWDATA}, {48'd0, mon_item[DW-1:0]});
      end
    end
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_grant"},    {60'd0, grant}, 64'd0);
    chk({name, "_pready"},   {60'd0, S_PREADY}, 64'd0);
    chk({name, "_prdata"},   S_PRDATA, 64'd0);
    chk({name, "_mctl"},     {61'd0, M_PSEL, M_PENABLE, timeout}, 64'd0);
    chk({name, "_mpaddr"},   {44'd0, M_PADDR}, 64'd0);
    chk({name, "_mpwdata"},  {47'd0, M_PWRITE, M_PWDATA}, 64'd0);
  endtask

  int            prev_done;
  int            req_cyc;
  int            first;
  logic [N-1:0]  served;
  logic [N-1:0]  pend;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // T1: master 2 writes 0x0042 to 0x00010, slave ready immediately
    slave_wait = 0; slave_rdata = 16'h0000;
    step();
    set_master(2, 20'h00010, 1'b1, 16'h0042);
    push_exp(2, 16'h0000, 1'b0, 20'h00010, 1'b1, 16'h0042);
    @(negedge clk);
    chk("t1_idle_psel", {63'd0, M_PSEL}, 64'd0);
    step();
    @(negedge clk);
    chk("t1_setup_grant", {60'd0, grant}, 64'h4);
    chk("t1_setup_ctl", {62'd0, M_PSEL, M_PENABLE}, 64'h2);
    chk("t1_setup_state", {62'd0, dbg_state}, 64'h1);
    chk("t1_setup_pwdata", {48'd0, M_PWDATA}, 64'h0042);
    step();
    @(negedge clk);
    chk("t1_access_ctl", {62'd0, M_PSEL, M_PENABLE}, 64'h3);
    chk("t1_access_pready", {60'd0, S_PREADY}, 64'h4);
    step();
    S_PSELx[2] = 1'b0;
    @(negedge clk);
    chk("t1_after_grant", {60'd0, grant}, 64'd0);
    chk("t1_after_psel", {63'd0, M_PSEL}, 64'd0);

    // T3: master 1 read, 5 wait cycles, address change and PSEL drop ignored mid-transfer
    slave_wait = 5; slave_rdata = 16'hBEEF;
    step();
    set_master(1, 20'h00020, 1'b0, 16'h1111);
    push_exp(1, 16'hBEEF, 1'b0, 20'h00020, 1'b0, 16'h1111);
    step();
    S_PADDR[1*BW +: BW] = 20'hFFFFF;
    @(negedge clk);
    chk("t3_setup_grant", {60'd0, grant}, 64'h2);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) S_PSELx[1] = 1'b0;
      @(negedge clk);
      if (c < 6) begin
        chk("t3_wait_pready", {60'd0, S_PREADY}, 64'd0);
      end else begin
        chk("t3_done_pready", {60'd0, S_PREADY}, 64'h2);
        chk("t3_done_prdata", S_PRDATA, 64'h0000_0000_BEEF_0000);
      end
    end
    step();
    @(negedge clk);
    chk("t3_back_idle", {62'd0, M_PSEL, M_PENABLE}, 64'd0);

    // T4: slave never ready, forced completion in 8th ACCESS cycle
    slave_wait = -1; slave_rdata = 16'h7777;
    step();
    set_master(2, 20'h00030, 1'b1, 16'h2222);
    push_exp(2, 16'hDEAD, 1'b1, 20'h00030, 1'b1, 16'h2222);
    step();
    for (int c = 1; c <= TO; c++) begin
      step();
      @(negedge clk);
      if (c < TO) begin
        chk("t4_wait", {59'd0, timeout, S_PREADY}, 64'd0);
      end else begin
        chk("t4_forced", {59'd0, timeout, S_PREADY}, 64'h14);
        chk("t4_err_data", S_PRDATA, 64'h0000_DEAD_0000_0000);
      end
    end
    step();
    S_PSELx[2] = 1'b0;
    @(negedge clk);
    chk("t4_back_idle", {59'd0, timeout, grant}, 64'd0);
    chk("t4_back_ctl", {62'd0, M_PSEL, M_PENABLE}, 64'd0);

    // T4b: slave ready in the last watchdog cycle wins over forced completion
    slave_wait = TO - 1; slave_rdata = 16'h5A5A;
    step();
    set_master(0, 20'h00040, 1'b0, 16'h3333);
    push_exp(0, 16'h5A5A, 1'b0, 20'h00040, 1'b0, 16'h3333);
    step();
    for (int c = 1; c <= TO; c++) begin
      step();
      @(negedge clk);
      if (c == TO) chk("t4b_ready_wins", {59'd0, timeout, S_PREADY}, 64'h01);
    end
    step();
    S_PSELx[0] = 1'b0;

    // T6: reset during ACCESS drops the transfer with no PREADY
    slave_wait = -1;
    step();
    set_master(3, 20'h00050, 1'b1, 16'h4444);
    step();
    step();
    @(negedge clk);
    chk("t6_in_access", {59'd0, M_PENABLE, grant}, 64'h18);
    step();
    reset = 1'b1;
    S_PSELx = '0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("t6_after_reset");

    // T2: all four request from reset; order 0,1,2,3 at 3 cycles each
    slave_wait = 0; slave_rdata = 16'h1234;
    step();
    for (int i = 0; i < N; i++) begin
      set_master(i, 20'h00100 + BW'(i), i[0], 16'hA000 + DW'(i));
      push_exp(i, 16'h1234, 1'b0, 20'h00100 + BW'(i), i[0], 16'hA000 + DW'(i));
    end
    req_cyc = cyc;
    served = '0;
    first = 1;
    prev_done = 0;
    for (int c = 0; c < 40 && served != 4'hF; c++) begin
      @(negedge clk);
      pend = S_PREADY;
      if (pend != '0) begin
        if (first == 1) chk("t2_first_latency", 64'(cyc - req_cyc), 64'd2);
        else            chk("t2_spacing", 64'(cyc - prev_done), 64'd3);
        first = 0;
        prev_done = cyc;
      end
      step();
      S_PSELx = S_PSELx & ~pend;
      served = served | pend;
    end
    chk("t2_all_served", {60'd0, served}, 64'hF);

    // T5: ptr wrapped to 0; master 0 holds PSEL an extra cycle while master 3 requests
    step();
    set_master(0, 20'h00200, 1'b1, 16'h5555);
    set_master(3, 20'h00203, 1'b0, 16'h6666);
    push_exp(0, 16'h1234, 1'b0, 20'h00200, 1'b1, 16'h5555);
    push_exp(3, 16'h1234, 1'b0, 20'h00203, 1'b0, 16'h6666);
    step();
    @(negedge clk);
    chk("t5_first_m0", {60'd0, grant}, 64'h1);
    step();
    @(negedge clk);
    chk("t5_m0_pready", {60'd0, S_PREADY}, 64'h1);
    step();
    @(negedge clk);
    chk("t5_idle_psel", {63'd0, M_PSEL}, 64'd0);
    step();
    S_PSELx[0] = 1'b0;
    @(negedge clk);
    chk("t5_m3_next", {60'd0, grant}, 64'h8);
    step();
    @(negedge clk);
    chk("t5_m3_pready", {60'd0, S_PREADY}, 64'h8);
    step();
    S_PSELx[3] = 1'b0;
    @(negedge clk);
    chk("t5_end_grant", {60'd0, grant}, 64'd0);

    // T5b: lone master holding PSEL after its PREADY is not regranted
    step();
    set_master(1, 20'h00300, 1'b1, 16'h7777);
    push_exp(1, 16'h1234, 1'b0, 20'h00300, 1'b1, 16'h7777);
    step();
    step();
    @(negedge clk);
    chk("t5b_pready", {60'd0, S_PREADY}, 64'h2);
    step();
    step();
    S_PSELx[1] = 1'b0;
    @(negedge clk);
    chk("t5b_no_regrant", {59'd0, M_PSEL, grant}, 64'd0);

    repeat (5) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
